// File: rtl/ama_riscv_hpm.sv
// RISC-V hardware performance monitor: NUM_CNT event counters with selectors, inhibit and overflow IRQ.
// CSR reads are combinational; writes and counting land on the next clk edge; always ready, no backpressure.
module ama_riscv_hpm #(
  parameter int NUM_CNT = 6,
  parameter int CNT_W   = 64,
  parameter int NUM_EVT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               re,
  input  logic               we,
  input  logic [1:0]         op,
  input  logic [11:0]        addr,
  input  logic [31:0]        wdata,
  input  logic [NUM_EVT-1:0] events,
  output logic [31:0]        rdata,
  output logic               hit,
  output logic               ovf_irq
);
  localparam int TOP = 3 + NUM_CNT;

  logic [CNT_W-1:0]   cnt     [NUM_CNT];
  logic [CNT_W-1:0]   cnt_nxt [NUM_CNT];
  logic [7:0]         sel     [NUM_CNT];
  logic [NUM_CNT-1:0] inhibit, ovf_sts, ovf_en, ovf_set, sts_nxt;
  logic [255:0]       evt_pad;
  logic               is_lo, is_hi, is_evt, is_inh, is_sts, is_en, impl, commit;
  logic [31:0]        csr_val, wval;

  assign is_lo  = (addr[11:7] == 5'h16) && (addr[6:0] >= 7'd3) && (addr[6:0] < 7'(TOP));
  assign is_hi  = (addr[11:7] == 5'h17) && (addr[6:0] >= 7'd3) && (addr[6:0] < 7'(TOP));
  assign is_evt = (addr[11:5] == 7'h19) && (addr[4:0] >= 5'd3) && ({1'b0, addr[4:0]} < 6'(TOP));
  assign is_inh = (addr == 12'h320);
  assign is_sts = (addr == 12'h7C0);
  assign is_en  = (addr == 12'h7C1);
  assign impl   = is_lo || is_hi || is_evt || is_inh || is_sts || is_en;
  assign hit    = impl && (re || we);
  assign commit = we && (op != 2'b00) && impl;

  // Selector 0 maps to the padding zero, as does anything above NUM_EVT.
  assign evt_pad = 256'({events, 1'b0});

  always_comb begin
    csr_val = '0;
    for (int n = 0; n < NUM_CNT; n++) begin
      if (addr[6:0] == 7'(n + 3)) begin
        if (is_lo) csr_val = 32'(cnt[n]);
        if (is_hi) csr_val = 32'(64'(cnt[n]) >> 32);
      end
      if (is_evt && (addr[4:0] == 5'(n + 3))) csr_val = {24'h0, sel[n]};
    end
    if (is_inh) csr_val = 32'({inhibit, 3'b000});
    if (is_sts) csr_val = 32'({ovf_sts, 3'b000});
    if (is_en)  csr_val = 32'({ovf_en, 3'b000});
  end

  assign rdata = re ? csr_val : '0;

  always_comb begin
    case (op)
      2'b01:   wval = wdata;
      2'b10:   wval = csr_val | wdata;
      2'b11:   wval = csr_val & ~wdata;
      default: wval = csr_val;
    endcase
  end

  // A CSR write to either half pre-empts that counter's increment for the cycle.
  always_comb begin
    ovf_set = '0;
    for (int n = 0; n < NUM_CNT; n++) begin
      cnt_nxt[n] = cnt[n];
      if (commit && is_lo && (addr[6:0] == 7'(n + 3))) begin
        cnt_nxt[n] = CNT_W'({32'(64'(cnt[n]) >> 32), wval});
      end else if (commit && is_hi && (addr[6:0] == 7'(n + 3))) begin
        cnt_nxt[n] = CNT_W'({wval, 32'(cnt[n])});
      end else if (evt_pad[sel[n]] && !inhibit[n]) begin
        cnt_nxt[n] = cnt[n] + CNT_W'(1);
        ovf_set[n] = &cnt[n];
      end
    end
    sts_nxt = (commit && is_sts) ? wval[TOP-1:3] : ovf_sts;
    sts_nxt = sts_nxt | ovf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_CNT; n++) begin
        cnt[n] <= '0;
        sel[n] <= '0;
      end
      inhibit <= '0;
      ovf_sts <= '0;
      ovf_en  <= '0;
      ovf_irq <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_CNT; n++) begin
        cnt[n] <= cnt_nxt[n];
        if (commit && is_evt && (addr[4:0] == 5'(n + 3))) sel[n] <= wval[7:0];
      end
      if (commit && is_inh) inhibit <= wval[TOP-1:3];
      if (commit && is_en)  ovf_en  <= wval[TOP-1:3];
      ovf_sts <= sts_nxt;
      ovf_irq <= |(ovf_sts & ovf_en);
    end
  end
endmodule

// File: tb/tb_ama_riscv_hpm.sv
// Directed bench for ama_riscv_hpm (NUM_CNT=2, CNT_W=40, NUM_EVT=8) with a per-cycle reference model.
module tb_ama_riscv_hpm;
  localparam logic [63:0] MASK = 64'hFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re = 1'b0, we = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [11:0] addr = 12'h000;
  logic [31:0] wdata = 32'h0;
  logic [7:0]  events = 8'h00;
  logic [31:0] rdata;
  logic        hit, ovf_irq;

  int n_chk = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  ama_riscv_hpm #(.NUM_CNT(2), .CNT_W(40), .NUM_EVT(8)) dut (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .op(op), .addr(addr),
    .wdata(wdata), .events(events), .rdata(rdata), .hit(hit), .ovf_irq(ovf_irq)
  );

  always #5 clk = ~clk;

  // Reference state: counters 3 and 4 live at index 0 and 1.
  longint unsigned m_cnt [2];
  logic [7:0]      m_sel [2];
  logic [1:0]      m_inh, m_sts, m_en;
  logic            m_irq;

  function automatic logic [31:0] mread(input logic [11:0] a);
    mread = 32'h0;
    for (int m = 0; m < 2; m++) begin
      if (a == 12'(12'hB03 + m)) mread = 32'(m_cnt[m]);
      if (a == 12'(12'hB83 + m)) mread = 32'(m_cnt[m] >> 32);
      if (a == 12'(12'h323 + m)) mread = {24'h0, m_sel[m]};
    end
    if (a == 12'h320) mread = {27'h0, m_inh, 3'b000};
    if (a == 12'h7C0) mread = {27'h0, m_sts, 3'b000};
    if (a == 12'h7C1) mread = {27'h0, m_en, 3'b000};
  endfunction

  function automatic logic mhit(input logic [11:0] a);
    mhit = (a == 12'h320) || (a == 12'h7C0) || (a == 12'h7C1);
    for (int m = 0; m < 2; m++)
      if (a == 12'(12'hB03 + m) || a == 12'(12'hB83 + m) || a == 12'(12'h323 + m)) mhit = 1'b1;
  endfunction

  function automatic logic mcommit();
    mcommit = we && (op != 2'b00) && mhit(addr);
  endfunction

  function automatic logic [31:0] mwv();
    case (op)
      2'b01:   mwv = wdata;
      2'b10:   mwv = mread(addr) | wdata;
      2'b11:   mwv = mread(addr) & ~wdata;
      default: mwv = 32'h0;
    endcase
  endfunction

  function automatic logic mevt(input logic [7:0] s);
    mevt = (s >= 8'd1 && s <= 8'd8) ? events[s - 8'd1] : 1'b0;
  endfunction

  function automatic logic mfires(input int m);
    logic written;
    written = mcommit() && (addr == 12'(12'hB03 + m) || addr == 12'(12'hB83 + m));
    mfires = !written && mevt(m_sel[m]) && !m_inh[m];
  endfunction

  function automatic logic mwrap(input int m);
    mwrap = mfires(m) && (m_cnt[m] == MASK);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_cnt[m] <= 0;
        m_sel[m] <= 8'h0;
      end
      m_inh <= 2'b0;
      m_sts <= 2'b0;
      m_en  <= 2'b0;
      m_irq <= 1'b0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (mcommit() && addr == 12'(12'hB03 + m))
          m_cnt[m] <= (m_cnt[m] & ~64'hFFFF_FFFF) | 64'(mwv());
        else if (mcommit() && addr == 12'(12'hB83 + m))
          m_cnt[m] <= ((64'(mwv()) << 32) | (m_cnt[m] & 64'hFFFF_FFFF)) & MASK;
        else if (mfires(m))
          m_cnt[m] <= (m_cnt[m] + 1) & MASK;
        if (mcommit() && addr == 12'(12'h323 + m)) m_sel[m] <= 8'(mwv());
      end
      if (mcommit() && addr == 12'h320) m_inh <= 2'(mwv() >> 3);
      if (mcommit() && addr == 12'h7C1) m_en  <= 2'(mwv() >> 3);
      m_sts <= ((mcommit() && addr == 12'h7C0) ? 2'(mwv() >> 3) : m_sts) | {mwrap(1), mwrap(0)};
      m_irq <= |(m_sts & m_en);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_rdata", rdata, re ? mread(addr) : 32'h0);
      check("model_hit", {31'h0, hit}, {31'h0, mhit(addr) && (re || we)});
      check("model_irq", {31'h0, ovf_irq}, {31'h0, m_irq});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] o);
    we = 1'b1; re = 1'b1; op = o; addr = a; wdata = d;
    tick();
    we = 1'b0; op = 2'b00;
  endtask

  task automatic rd_expect(input string nm, input logic [11:0] a, input logic [31:0] e);
    tick();
    re = 1'b1; addr = a;
    #1;
    check(nm, rdata, e);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    re = 1'b1; addr = 12'hB03;
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'h0, ovf_irq}, 32'h0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Event count: selector 2 follows events[1]
    wr(12'h323, 32'h2, 2'b01);
    events = 8'h02;
    repeat (5) tick();
    events = 8'h00;
    rd_expect("cnt3_lo_5", 12'hB03, 32'h5);
    rd_expect("cnt3_hi_0", 12'hB83, 32'h0);

    // Inhibit then write priority over increment
    wr(12'h320, 32'h8, 2'b01);
    events = 8'h02;
    repeat (10) tick();
    rd_expect("inhibit_hold", 12'hB03, 32'h5);
    wr(12'h320, 32'h0, 2'b01);
    wr(12'hB03, 32'h10, 2'b01);
    #1;
    check("wr_priority", rdata, 32'h10);
    tick();
    #1;
    check("count_after_wr", rdata, 32'h11);
    events = 8'h00;

    // RS/RC and selector width
    wr(12'h324, 32'h1FF, 2'b01);
    rd_expect("sel_8bit", 12'h324, 32'hFF);
    wr(12'h324, 32'h03, 2'b01);
    wr(12'h324, 32'h04, 2'b10);
    wr(12'h324, 32'h01, 2'b11);
    rd_expect("sel_rs_rc", 12'h324, 32'h6);

    // Wrap and IRQ on 40-bit counter 3
    wr(12'hB83, 32'h1FF, 2'b01);
    rd_expect("hi_trunc", 12'hB83, 32'hFF);
    wr(12'hB03, 32'hFFFF_FFFF, 2'b01);
    wr(12'h7C1, 32'h8, 2'b01);
    events = 8'h02;
    tick();
    events = 8'h00;
    #1;
    check("irq_lag", {31'h0, ovf_irq}, 32'h0);
    tick();
    #1;
    check("irq_set", {31'h0, ovf_irq}, 32'h1);
    rd_expect("wrap_lo", 12'hB03, 32'h0);
    rd_expect("wrap_hi", 12'hB83, 32'h0);
    rd_expect("ovf_sts3", 12'h7C0, 32'h8);
    wr(12'h7C0, 32'h8, 2'b11);
    #1;
    check("irq_clr_lag", {31'h0, ovf_irq}, 32'h1);
    tick();
    #1;
    check("irq_clr", {31'h0, ovf_irq}, 32'h0);

    // Hardware set beats simultaneous RC clear on counter 4 (selector 6)
    wr(12'hB84, 32'hFF, 2'b01);
    wr(12'hB04, 32'hFFFF_FFFF, 2'b01);
    events = 8'h20;
    wr(12'h7C0, 32'h10, 2'b11);
    events = 8'h00;
    rd_expect("sts4_wins", 12'h7C0, 32'h10);
    rd_expect("cnt4_wrap", 12'hB04, 32'h0);
    wr(12'hB04, 32'h0, 2'b01);
    rd_expect("wr0_no_ovf", 12'h7C0, 32'h10);

    // Unimplemented addresses and out-of-range selectors
    rd_expect("unimpl_b05", 12'hB05, 32'h0);
    check("unimpl_hit", {31'h0, hit}, 32'h0);
    rd_expect("unimpl_321", 12'h321, 32'h0);
    check("unimpl321_hit", {31'h0, hit}, 32'h0);
    wr(12'hB05, 32'h1234, 2'b01);
    wr(12'h323, 32'hFF, 2'b01);
    events = 8'hFF;
    repeat (4) tick();
    events = 8'h00;
    rd_expect("sel_ff_none", 12'hB03, 32'h0);
    wr(12'h323, 32'h9, 2'b01);
    events = 8'hFF;
    repeat (3) tick();
    events = 8'h00;
    rd_expect("sel_9_none", 12'hB03, 32'h0);

    // Asynchronous reset pulse between edges
    wr(12'h7C1, 32'h18, 2'b01);
    wr(12'hB03, 32'h77, 2'b01);
    tick();
    #1;
    check("irq_pre_rst", {31'h0, ovf_irq}, 32'h1);
    tick();
    rst_n = 1'b0; re = 1'b1; addr = 12'hB03;
    #1;
    check("arst_cnt", rdata, 32'h0);
    check("arst_irq", {31'h0, ovf_irq}, 32'h0);
    addr = 12'h7C1;
    #1;
    check("arst_en", rdata, 32'h0);
    addr = 12'h7C0;
    #1;
    check("arst_sts", rdata, 32'h0);
    rst_n = 1'b1;

    // Reset spanning an edge aborts an in-flight write
    we = 1'b1; op = 2'b01; addr = 12'hB84; wdata = 32'h55;
    rst_n = 1'b0;
    tick();
    we = 1'b0; op = 2'b00;
    rst_n = 1'b1;
    rd_expect("rst_abort_wr", 12'hB84, 32'h0);

    // Counting resumes right after reset
    wr(12'h323, 32'h1, 2'b01);
    events = 8'h01;
    tick();
    events = 8'h00;
    rd_expect("post_rst_cnt", 12'hB03, 32'h1);

    tick();
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ama_riscv_hpm.md
AMA_RISCV_HPM -- requirements
Module: ama_riscv_hpm

Interface
REQ-001 SHALL have parameter NUM_CNT, default 6, meaning the number of implemented counters, legal range 1..29, mapped to mhpmcounter3..(3+NUM_CNT-1).
REQ-002 SHALL have parameter CNT_W, default 64, meaning the counter width, legal range 32..64.
REQ-003 SHALL have parameter NUM_EVT, default 8, meaning the number of event inputs, legal range 1..255.
REQ-004 SHALL have port clk  input  1  rising-edge clock; the block uses one clock.
REQ-005 SHALL have port rst_n  input  1  reset; it is asynchronous and active-low.
REQ-006 SHALL have port re  input  1  CSR read enable.
REQ-007 SHALL have port we  input  1  CSR write enable.
REQ-008 SHALL have port op  input  2  CSR op: 01=RW, 10=RS, 11=RC, 00=no write.
REQ-009 SHALL have port addr  input  12  CSR address.
REQ-010 SHALL have port wdata  input  32  write source operand.
REQ-011 SHALL have port events  input  NUM_EVT  per-cycle event pulses; bit k is event k+1.
REQ-012 SHALL have port rdata  output  32  combinational read data.
REQ-013 SHALL have port hit  output  1  high when addr decodes to an implemented register and re or we is asserted.
REQ-014 SHALL have port ovf_irq  output  1  registered overflow interrupt.

Function
REQ-015 SHALL decode the following addresses: mhpmcounterN low 0xB00+N; high 0xB80+N; mhpmeventN 0x320+N, for N=3..2+NUM_CNT; mcountinhibit 0x320; ovf status 0x7C0; ovf enable 0x7C1.
REQ-016 SHALL drive rdata=0 when re=0 or the address is unimplemented; counters with index >= 3+NUM_CNT are unimplemented.
REQ-017 SHALL read the counter high half as bits [CNT_W-1:32] zero-extended; when CNT_W=32, the high half SHALL read 0 and ignore writes.
REQ-018 SHALL compute write data as: RW=wdata; RS=rdata|wdata; RC=rdata&~wdata; commit on the rising edge when we=1 and op!=00.
REQ-019 SHALL store mhpmeventN as 8 bits, wdata[7:0]; on read, bits [31:8] SHALL be 0.
REQ-020 SHALL treat an event selector of 0, or any selector > NUM_EVT, as no event; selector k (1..NUM_EVT) selects events[k-1].
REQ-021 SHALL store mcountinhibit bits [3+NUM_CNT-1:3]; all other bits SHALL read 0.
REQ-022 SHALL increment counter N by 1 in a cycle when its selected event is 1 and inhibit bit N is 0.
REQ-023 SHALL give a CSR write to either half of counter N priority over that counter's increment in that cycle; the other half holds its value and no increment occurs.
REQ-024 SHALL wrap a counter from all-ones (CNT_W bits) to 0 on increment and set sticky ovf status bit N in the same edge.
REQ-025 SHALL NOT set ovf status when a CSR write loads 0.
REQ-026 SHALL apply the CSR-written value to the ovf status register, except that a hardware overflow set in the same cycle wins for that bit.
REQ-027 SHALL restrict ovf status and ovf enable to bits [3+NUM_CNT-1:3]; all other bits SHALL read 0.
REQ-028 SHALL register ovf_irq as |(ovf_status & ovf_enable); it therefore lags a status/enable change by one cycle.
REQ-029 SHALL leave all state unchanged on a write to an unimplemented address, with hit=0.

Reset
REQ-030 SHALL, while rst_n=0 (asynchronously), clear all counters, event selectors, mcountinhibit, ovf status, ovf enable and ovf_irq to 0.
REQ-031 SHALL, because rdata is combinational, give rdata=0 during reset for any address.
REQ-032 SHALL abort a reset asserted mid-write, with no partial update surviving.
REQ-033 SHALL resume counting on the first rising edge after rst_n deasserts.

Verification
REQ-034 Event count: set mhpmevent3=2, pulse events[1] for 5 cycles -> mhpmcounter3 low=5, high=0.
REQ-035 Inhibit/priority: set mcountinhibit bit 3, assert the selected event for 10 cycles -> counter unchanged; then clear the bit and RW-write counter low=0x10 while the event is high -> reads 0x10 next cycle, 0x11 the cycle after.
REQ-036 Wrap/IRQ: set CNT_W=40, write high=0xFF and low=0xFFFFFFFF, set ovf enable bit 3, fire 1 event -> counter=0, ovf status bit 3=1, ovf_irq=1 one cycle later; RC on 0x7C0 with bit 3 -> ovf_irq=0 one cycle after the clear.
REQ-037 Simultaneous set/clear: RC-clear ovf bit 4 in the same cycle counter4 wraps -> bit 4 remains 1.
REQ-038 Unimplemented/selector: with NUM_CNT=2, read 0xB05 -> rdata=0, hit=0; with selector 0xFF (> NUM_EVT) and all events high -> no increment.
REQ-039 Async reset: pulse rst_n low mid-cycle for less than one clock -> all registers read 0 immediately, with no clock edge needed.
